// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing the single-port MIPS memory between instruction fetch and data.
// Data wins contention until the fetch port has lost STARVE_LIMIT times in a row.
module mips_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byte_en,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_address,
  output logic        mem_wr_en,
  output logic        mem_read_en,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_active
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ird_q, ird_d;
  logic [31:0] drd_q, drd_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        win_i_q, win_i_d;
  logic        mact_q, mact_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        grant_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ird_d   = ird_q;
    drd_d   = drd_q;
    be_d    = be_q;
    we_d    = we_q;
    win_i_d = win_i_q;
    cnt_d   = cnt_q;
    grant_i = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (active && (i_req || d_req)) begin
          grant_i = i_req && (!d_req || cnt_q == LIMIT);
          state_d = ISSUE;
          win_i_d = grant_i;
          if (grant_i) begin
            addr_d = i_addr;
            be_d   = 4'hF;
            we_d   = 1'b0;
            cnt_d  = 8'd0;
          end else begin
            addr_d  = d_addr;
            be_d    = d_byte_en;
            we_d    = d_we;
            wdata_d = d_wdata;
            // Only contested data grants count toward starvation.
            if (i_req && cnt_q != LIMIT)
              cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ISSUE: begin
        state_d = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        if (win_i_q)
          ird_d = mem_data_out;
        else
          drd_d = mem_data_out;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  // Looks at the next state so memory goes quiet in the first idle cycle.
  assign mact_d = active || (state_d != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ird_q   <= '0;
      drd_q   <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      win_i_q <= 1'b0;
      mact_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ird_q   <= ird_d;
      drd_q   <= drd_d;
      be_q    <= be_d;
      we_q    <= we_d;
      win_i_q <= win_i_d;
      mact_q  <= mact_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_read_en = (state_q == ISSUE) && !we_q;
  assign mem_wr_en   = (state_q == ISSUE) && we_q;
  assign i_ack       = (state_q == RESP) && win_i_q;
  assign d_ack       = (state_q == RESP) && !win_i_q;
  assign mem_address = addr_q;
  assign mem_byte_en = be_q;
  assign mem_data_in = wdata_q;
  assign i_rdata     = ird_q;
  assign d_rdata     = drd_q;
  assign mem_active  = mact_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter with a behavioural memory and
// a transaction-level model of grant order, latency and read data.
module tb_mips_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_byte_en = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] mem_address;
  logic        mem_wr_en;
  logic        mem_read_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_active;

  mips_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .active(active),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byte_en(d_byte_en),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_read_en(mem_read_en), .mem_byte_en(mem_byte_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_active(mem_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_i;
    int unsigned cyc;
    logic [31:0] ird;
    logic [31:0] drd;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] mem_arr [256];
  logic [31:0] h_i = '0;
  logic [31:0] h_d = '0;
  int          cnt = 0;
  bit          ip = 0;
  bit          dp = 0;

  function automatic logic [31:0] init_val(int i);
    if (i == 4) return 32'h8C220004;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Memory: loads known contents in reset, 1-cycle registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
    end else begin
      if (mem_wr_en)
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b])
            mem_arr[mem_address[9:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
      if (mem_read_en) mem_data_out <= mem_arr[mem_address[9:2]];
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic init_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return {r[31:10], 4'b0000, r[3:0], 2'b00};
  endfunction

  // Monitor: every ack must match the oldest predicted completion.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr_en || mem_read_en)
        chk("rd_wr_exclusive", {31'b0, mem_wr_en & mem_read_en}, 32'd0);
      if (i_ack || d_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", {30'b0, i_ack, d_ack}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_port", {30'b0, i_ack, d_ack}, e.is_i ? 32'd2 : 32'd1);
          chk("ack_cycle", cyc, e.cyc);
          chk("i_rdata", i_rdata, e.ird);
          chk("d_rdata", d_rdata, e.drd);
        end
      end
    end
  end

  // Called in an IDLE cycle just after a rising edge.
  task automatic run_txn(input int p, input bit halt);
    bit   win_i, rd, got;
    exp_t e;
    if (!ip && $urandom_range(99) < p) begin
      ip = 1; i_req = 1; i_addr = rand_addr();
    end
    if (!dp && $urandom_range(99) < p) begin
      dp = 1; d_req = 1; d_we = 1'($urandom_range(1));
      d_addr = rand_addr(); d_byte_en = 4'($urandom); d_wdata = $urandom;
    end
    if (!ip && !dp) begin
      @(posedge clk); #1;
      return;
    end
    win_i = ip && (!dp || cnt == LIMIT);
    if (win_i) cnt = 0;
    else if (ip && cnt < LIMIT) cnt++;
    rd = win_i || !d_we;
    if (win_i) h_i = ref_mem[i_addr[9:2]];
    else if (!d_we) h_d = ref_mem[d_addr[9:2]];
    else
      for (int b = 0; b < 4; b++)
        if (d_byte_en[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
    e.is_i = win_i;
    e.cyc  = cyc + (rd ? 3 : 2);
    e.ird  = h_i;
    e.drd  = h_d;
    q.push_back(e);
    @(posedge clk); #1;
    if (halt) active = 0;
    chk("issue_rd_en", {31'b0, mem_read_en}, {31'b0, rd});
    chk("issue_wr_en", {31'b0, mem_wr_en}, {31'b0, !rd});
    chk("issue_addr", mem_address, win_i ? i_addr : d_addr);
    chk("issue_be", {28'b0, mem_byte_en}, win_i ? 32'hF : {28'b0, d_byte_en});
    if (!rd) chk("issue_wdata", mem_data_in, d_wdata);
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(posedge clk); #1;
      got = win_i ? i_ack : d_ack;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    if (halt) chk("mem_active_resp", {31'b0, mem_active}, 32'd1);
    if (win_i) begin ip = 0; i_req = 0; end
    else begin dp = 0; d_req = 0; end
    @(posedge clk); #1;
    if (halt) chk("mem_active_halt", {31'b0, mem_active}, 32'd0);
  endtask

  initial begin
    init_ref();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_ack", {31'b0, i_ack}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst_rd_en", {31'b0, mem_read_en}, 32'd0);
    chk("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
    chk("rst_mem_active", {31'b0, mem_active}, 32'd1);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    reset = 0;
    @(posedge clk); #1;

    // Instruction fetch of 0x10.
    ip = 1; i_req = 1; i_addr = 32'h10;
    run_txn(0, 0);
    chk("fetch_word", h_i, 32'h8C220004);

    // Partial data write.
    dp = 1; d_req = 1; d_we = 1; d_addr = 32'h100;
    d_byte_en = 4'b0011; d_wdata = 32'hDEADBEEF;
    run_txn(0, 0);

    // Continuous contention: D,D,D,D,I repeating.
    for (int t = 0; t < 10; t++) run_txn(100, 0);
    ip = 0; i_req = 0; dp = 0; d_req = 0;

    // Halt in the ISSUE cycle of a data read.
    dp = 1; d_req = 1; d_we = 0; d_addr = rand_addr();
    run_txn(0, 1);
    ip = 1; i_req = 1; i_addr = rand_addr();
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      chk("halt_rd_en", {31'b0, mem_read_en}, 32'd0);
      chk("halt_mem_active", {31'b0, mem_active}, 32'd0);
    end
    active = 1;
    run_txn(0, 0);

    // Reset during CAPTURE drops the read; it is then re-issued.
    dp = 1; d_req = 1; d_we = 0; d_addr = rand_addr();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("midrst_rd_en", {31'b0, mem_read_en}, 32'd0);
    chk("midrst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("midrst_d_rdata", d_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    cnt = 0; h_i = '0; h_d = '0;
    init_ref();
    run_txn(0, 0);

    // Randomized mix with frequent contention.
    for (int t = 0; t < 250; t++) run_txn(60, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Shares the single-port byte-addressed MIPS memory between the CPU instruction-fetch port (read-only) and the data port (read/write with byte enables). Sits between the CPU and mips_memory, and serialises accesses through a 4-state FSM. Fixed data-port priority is bounded by a starvation limit for the fetch port. Also gates the memory's `active` signal so the end-of-run dump only sees a quiescent memory.

Parameters:
STARVE_LIMIT, 4, consecutive contested data grants after which the next contested grant goes to the instruction port (range 1..255).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
active  input  1  CPU running flag; 0 = halted
i_req  input  1  instruction read request, held until i_ack
i_addr  input  32  instruction byte address
i_rdata  output  32  instruction read data, valid while i_ack=1, held afterwards
i_ack  output  1  one-cycle completion pulse
d_req  input  1  data request, held until d_ack
d_we  input  1  1 = write, 0 = read
d_addr  input  32  data byte address
d_byte_en  input  4  write byte enables
d_wdata  input  32  write data
d_rdata  output  32  data read result, valid while d_ack=1, held afterwards
d_ack  output  1  one-cycle completion pulse
mem_address  output  32  to memory address
mem_wr_en  output  1  to memory wr_en
mem_read_en  output  1  to memory read_en
mem_byte_en  output  4  to memory byte_en
mem_data_in  output  32  to memory data_in
mem_data_out  input  32  from memory data_out (registered, 1-cycle read latency)
mem_active  output  1  to memory active

Behaviour:
- Reset (asynchronous, immediate):
  - FSM=IDLE.
  - i_ack, d_ack, mem_wr_en and mem_read_en = 0.
  - mem_address, mem_byte_en, mem_data_in, i_rdata and d_rdata = 0.
  - Starvation counter = 0. mem_active = 1.
- Reset mid-transaction: the transaction is dropped with no ack. The requester re-issues after reset.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If active=0, no grant.
  - Otherwise pick a winner and latch its address, we, byte_en and wdata into the mem_* registers; go to ISSUE.
  - Instruction grants force mem_byte_en=4'b1111 and we=0.
- Winner selection:
  - Only one request pending: grant it.
  - Both pending: grant data unless counter==STARVE_LIMIT, then grant instruction.
- Starvation counter:
  - +1 on each contested data grant, saturating at STARVE_LIMIT.
  - Cleared on any instruction grant.
  - Unchanged on an uncontested data grant.
- ISSUE (1 cycle):
  - Read: mem_read_en=1; next state CAPTURE.
  - Write: mem_wr_en=1; next state RESP.
  - mem_wr_en and mem_read_en are never both 1.
  - Both are 0 in every other state.
- CAPTURE (reads only, 1 cycle): mem_data_out is now valid. At the end of the cycle, load it into the winner's rdata register; next state RESP.
- RESP (1 cycle): the winner's ack=1; next state IDLE. The requester drops or changes req at the following edge.
- Latency, with req first sampled in IDLE at cycle N:
  - Read: ack in cycle N+3.
  - Write: ack in cycle N+2; the memory is written at the end of N+1.
  - Peak throughput is one read per 4 cycles or one write per 3 cycles.
- Held data: the rdata of the non-granted port and d_rdata after writes hold their previous value.
- Request inputs are sampled only in IDLE. Changes during ISSUE, CAPTURE or RESP are ignored.
- mem_active = 0 only when active=0 and FSM=IDLE; otherwise 1. This is a registered output, updated each edge.
  - A halt arriving mid-transaction completes that transaction before mem_active falls.
- Address arithmetic belongs to the memory. The arbiter passes 32-bit addresses unmodified, with no alignment checks.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with no requests -> all acks 0, mem_read_en=mem_wr_en=0, mem_active=1.
- Instruction fetch: memory preloaded so that mem_data_out returns 32'h8C220004 for address 0x00000010; i_req=1, i_addr=0x10 in cycle N -> mem_read_en=1 in N+1 with mem_address=0x10 and mem_byte_en=4'hF; i_ack=1 and i_rdata=32'h8C220004 in N+3; d_ack stays 0.
- Data write: d_req=1, d_we=1, d_addr=0x100, d_byte_en=4'b0011, d_wdata=32'hDEADBEEF -> mem_wr_en=1 in N+1 with mem_byte_en=4'b0011; d_ack in N+2; d_rdata unchanged.
- Contention and starvation, STARVE_LIMIT=4: i_req and d_req held continuously, each requester re-issuing right after its ack -> grant order D,D,D,D,I,D,D,D,D,I; counter clears after each I.
- Halt: active drops in the ISSUE cycle of a data read -> the read completes with d_ack in the expected cycle; mem_active=0 from the first cycle the FSM is IDLE; pending i_req is never granted while active=0.
- Reset mid-operation: reset asserted during CAPTURE -> FSM IDLE immediately, no ack produced, mem_read_en=0; after release the same request completes normally.
